mfm_quantize_adaptive: RTL
==========================

MFM_QUANTIZE_ADAPTIVE -- requirements
Module: mfm_quantize_adaptive

Interface
REQ-001 The block SHALL have parameter CLKSPD, default 65000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter ADJ_SHIFT, default 1, drift-loop gain shift (larger means slower tracking).
REQ-003 The block SHALL have parameter LOCK_COUNT, default 16, consecutive good symbols required for lock.
REQ-004 The block SHALL have port i_Clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port i_Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port i_Data, input, 1 bit: raw floppy read-data (asynchronous); a flux transition is a falling edge.
REQ-007 The block SHALL have port i_Mode, input, 1 bit: 0 selects HD (1 us cell), 1 selects DD (2 us cell).
REQ-008 The block SHALL have port i_Enable, input, 1 bit: 0 holds the block idle.
REQ-009 The block SHALL have port o_Valid, output, 1 bit: one-cycle strobe qualifying o_Sym.
REQ-010 The block SHALL have port o_Sym, output, 2 bits: 00 = S (2 cells), 01 = M (3 cells), 10 = L (4 cells), 11 = error.
REQ-011 The block SHALL have port o_Period, output, PW bits: the current tracked cell period in clocks.
REQ-012 The block SHALL have port o_Locked, output, 1 bit: the drift loop is locked.

Function
REQ-013 i_Data SHALL pass through a 2-flop synchroniser plus 1 history flop; an edge is detected in a cycle where the history bit is 1 and the synchronised bit is 0.
REQ-014 Nominal period SHALL be P0 = floor(CLKSPD/1e6) in HD and 2*P0 in DD; PW and the interval counter width SHALL hold 5*(2*P0 + P0/4) without overflow.
REQ-015 The state machine SHALL have two states: IDLE (waiting for a reference edge) and RUN (measuring).
REQ-016 IDLE -> RUN SHALL occur on an edge while i_Enable=1, with no o_Valid and the counter cleared.
REQ-017 In RUN, the counter SHALL increment by 1 per clock and saturate at all-ones; N is the count of clocks between consecutive edge-detect cycles.
REQ-018 Thresholds SHALL be computed from the tracked period P, with no division: TS = 2P + (P>>1), TM = 3P + (P>>1), TL = 4P + (P>>1).
REQ-019 On an edge in RUN: N < TS gives S, else N < TM gives M, else N < TL gives L; o_Valid=1 on the next clock and the counter is cleared; the state stays RUN.
REQ-020 In RUN, if the counter reaches TL with no edge, the block SHALL pulse o_Valid with o_Sym=11 and return to IDLE (timeout error).
REQ-021 o_Valid SHALL be a single-cycle pulse, registered, asserted on the 3rd rising i_Clk after the first edge that samples i_Data low.
REQ-022 Drift: on each S/M/L symbol, with e = N - k*P (signed, k = 2, 3 or 4), P SHALL take the value P + (e >>> (ADJ_SHIFT+1)), applied on the same clock as o_Valid.
REQ-023 P SHALL be clamped to [Pn - (Pn>>3), Pn + (Pn>>3)], where Pn is the nominal period for the current mode; error symbols SHALL NOT update P.
REQ-024 A good-symbol counter SHALL increment on S/M/L and saturate at LOCK_COUNT; o_Locked=1 SHALL hold while the counter equals LOCK_COUNT.
REQ-025 An error symbol SHALL clear the good-symbol counter and o_Locked on the o_Valid clock.
REQ-026 A change of i_Mode (detected against a registered copy) SHALL force IDLE, reload P to the new Pn, and clear the counters and o_Locked on the next clock; no o_Valid is issued for an interval that is in flight.
REQ-027 i_Enable=0 SHALL force IDLE and suppress o_Valid; P and the lock state SHALL be retained.
REQ-028 If an edge and a timeout coincide in the same cycle, the edge SHALL win and be classified as L.

Reset
REQ-029 While i_Rst_n=0, the block SHALL hold: state IDLE, counters 0, synchroniser flops 1, o_Valid=0, o_Sym=00, o_Locked=0, o_Period=Pn for the sampled i_Mode.
REQ-030 Reset SHALL take effect immediately and asynchronously mid-interval; the first edge after release SHALL only arm RUN.

Verification
REQ-031 HD mode, CLKSPD=65e6 (P=65, TS=162, TM=227, TL=292), edge spacings 130/195/260 SHALL yield S/M/L, one o_Valid each, and P unchanged.
REQ-032 An edge followed by no further edge for 292 clocks SHALL yield o_Valid with o_Sym=11, a return to IDLE, and o_Locked=0.
REQ-033 Repeated 136-clock spacings with ADJ_SHIFT=1 SHALL give P=66 after the first S, and P SHALL saturate at 73 and never exceed it.
REQ-034 Sixteen consecutive S symbols SHALL give o_Locked=1 on the 16th o_Valid; one following error SHALL drop o_Locked to 0 on the same clock.
REQ-035 Toggling i_Mode to DD mid-interval SHALL give o_Period=130, no o_Valid for that interval, and a 260-clock spacing afterwards SHALL classify as S.
REQ-036 Asserting i_Rst_n low mid-interval SHALL clear all outputs immediately, and the first post-reset edge SHALL produce no o_Valid.

Source files
------------

// File: rtl/mfm_quantize_adaptive.sv
// Purpose : MFM read-data quantiser; measures flux-transition spacing, classifies
//           it as S/M/L (2/3/4 cells) and tracks cell-period drift with lock status.
// Latency : o_Valid is registered, one clock after the edge-detect cycle
//           (3rd rising i_Clk after i_Data is first sampled low).
// Backpressure : none; the sink must accept every o_Valid strobe.
// Ports   : i_Clk/i_Rst_n clock and async active-low reset; i_Data raw read data
//           (falling edge = transition); i_Mode 0=HD 1=DD; i_Enable run/idle;
//           o_Valid/o_Sym symbol strobe and code; o_Period tracked period; o_Locked.
module mfm_quantize_adaptive #(
  parameter  int CLKSPD     = 65000000,
  parameter  int ADJ_SHIFT  = 1,
  parameter  int LOCK_COUNT = 16,
  localparam int P0         = CLKSPD / 1000000,
  localparam int PW         = $clog2(5 * (2 * P0 + P0 / 4) + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_Data,
  input  logic          i_Mode,
  input  logic          i_Enable,
  output logic          o_Valid,
  output logic [1:0]    o_Sym,
  output logic [PW-1:0] o_Period,
  output logic          o_Locked
);

  localparam logic [PW-1:0] PN_HD = PW'(P0);
  localparam logic [PW-1:0] PN_DD = PW'(2 * P0);
  localparam int            LW    = $clog2(LOCK_COUNT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);
  // Threshold math runs 3 bits wider than the period so 4P + P/2 never wraps.
  localparam int TW = PW + 3;
  localparam int EW = TW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic          sync1, sync2, hist;
  logic          mode_q;
  logic [PW-1:0] cnt;
  logic [PW-1:0] period;
  logic [LW-1:0] good;

  logic          edge_det;
  logic [PW:0]   n;
  logic [TW-1:0] ne, pe, ts, tm, tl, kp;
  logic [1:0]    sym_cls;
  logic          timeout;
  logic signed [EW-1:0] err, adj, p_sum, lo_s, hi_s;
  logic [PW-1:0] pn_cur, pn_new, lo, hi, p_next;
  logic [LW-1:0] good_next;

  assign edge_det = hist & ~sync2;
  assign o_Period = period;

  // cnt holds (clocks since last edge-detect cycle) - 1, so n is the spacing N.
  assign n  = {1'b0, cnt} + 1'b1;
  assign ne = {2'b00, n};
  assign pe = {3'b000, period};

  assign ts = (pe << 1) + (pe >> 1);
  assign tm = (pe << 1) + pe + (pe >> 1);
  assign tl = (pe << 2) + (pe >> 1);

  // An edge can only arrive with n <= TL in RUN (timeout fires at TL), so the
  // final else-branch covers the coincident edge/timeout case as L.
  always_comb begin
    sym_cls = 2'b10;
    kp      = pe << 2;
    if (ne < ts) begin
      sym_cls = 2'b00;
      kp      = pe << 1;
    end else if (ne < tm) begin
      sym_cls = 2'b01;
      kp      = (pe << 1) + pe;
    end
  end

  assign timeout = (ne >= tl);

  assign pn_cur = mode_q ? PN_DD : PN_HD;
  assign pn_new = i_Mode ? PN_DD : PN_HD;
  assign lo     = pn_cur - (pn_cur >> 3);
  assign hi     = pn_cur + (pn_cur >> 3);

  // Signed phase error, scaled by the loop gain with an arithmetic (floor) shift.
  assign err   = $signed({1'b0, ne}) - $signed({1'b0, kp});
  assign adj   = err >>> (ADJ_SHIFT + 1);
  assign p_sum = $signed({1'b0, pe}) + adj;
  assign lo_s  = $signed({{(EW - PW){1'b0}}, lo});
  assign hi_s  = $signed({{(EW - PW){1'b0}}, hi});

  always_comb begin
    p_next = p_sum[PW-1:0];
    if (p_sum < lo_s) begin
      p_next = lo;
    end else if (p_sum > hi_s) begin
      p_next = hi;
    end
  end

  assign good_next = (good == LOCK_MAX) ? good : good + 1'b1;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      hist     <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      good     <= '0;
      o_Valid  <= 1'b0;
      o_Sym    <= 2'b00;
      o_Locked <= 1'b0;
      // Period comes up at the nominal value for whatever mode is strapped.
      period   <= i_Mode ? PN_DD : PN_HD;
      mode_q   <= i_Mode;
    end else begin
      sync1   <= i_Data;
      sync2   <= sync1;
      hist    <= sync2;
      o_Valid <= 1'b0;

      if (i_Mode != mode_q) begin
        // Mode switch abandons any interval in flight and restarts tracking.
        mode_q   <= i_Mode;
        state    <= IDLE;
        cnt      <= '0;
        period   <= pn_new;
        good     <= '0;
        o_Locked <= 1'b0;
      end else if (!i_Enable) begin
        // Disabled: park in IDLE but keep the learned period and lock state.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (edge_det) begin
              state <= RUN;
              cnt   <= '0;
            end
          end
          RUN: begin
            if (edge_det) begin
              o_Valid  <= 1'b1;
              o_Sym    <= sym_cls;
              cnt      <= '0;
              period   <= p_next;
              good     <= good_next;
              o_Locked <= (good_next == LOCK_MAX);
            end else if (timeout) begin
              o_Valid  <= 1'b1;
              o_Sym    <= 2'b11;
              state    <= IDLE;
              cnt      <= '0;
              good     <= '0;
              o_Locked <= 1'b0;
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
